mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Three-way arbiter and sequencer for the single shared memory request port of the memory controller. It accepts level-held requests from the core, the IO controller and the audio controller, and serialises them one transaction at a time onto one request/done handshake. It returns read data and a one-cycle done pulse to the requester that was served. Audio has bounded-priority service for real-time playback; core and IO share the remaining slots round-robin.

## Interface
- ADDR_W, 19, address width of every requester and of the memory port
- DATA_W, 8, data width
- TIMEOUT, 255, maximum WAIT cycles before abort (only with ARB_TIMEOUT_EN)
- AUDIO_BURST, 2, maximum consecutive audio grants while core/IO are pending
- clk  in  1  single clock, rising edge
- clr  in  1  asynchronous active-high reset
- core_req, io_req, audio_req  in  1 each  level request, held until the matching done
- core_we, io_we  in  1 each  write enable; audio is read-only
- core_addr, io_addr, audio_addr  in  ADDR_W each  address
- core_wdata, io_wdata  in  DATA_W each  write data
- core_done, io_done, audio_done  out  1 each  one-cycle completion pulse
- core_rdata, io_rdata, audio_rdata  out  DATA_W each  registered read data, held until that requester's next done
- mem_req  out  1  request to memory controller
- mem_we  out  1  write enable to memory controller
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  read data, valid in the cycle of mem_done
- mem_done  in  1  one-cycle completion from memory controller
- grant_id  out  2  0 = none, 1 = core, 2 = io, 3 = audio
- err  out  1  one-cycle timeout pulse

## Operation
- States:
  - IDLE: no transaction; arbitrate.
  - WAIT: mem_req=1; wait for mem_done.
  - DONE: requester done=1; mem_req=0.
- IDLE: if any request is high, choose a winner. Latch its we/addr/wdata into mem_we/mem_addr/mem_wdata, latch grant_id, go to WAIT. Audio mem_we is always 0.
- Priority:
  - audio_req wins unless audio_cnt == AUDIO_BURST and core_req or io_req is high.
  - Otherwise core vs IO by round-robin pointer rr: rr=0 prefers core, rr=1 prefers IO. A lone requester always wins.
  - rr toggles on every core or IO grant.
- audio_cnt:
  - increments on each audio grant, saturating at AUDIO_BURST.
  - clears on any core or IO grant.
  - clears on an IDLE cycle with no audio_req.
- WAIT: mem_req held at 1 with stable address and data. When mem_done=1, capture mem_rdata into the granted requester's rdata and go to DONE.
- DONE: pulse the granted requester's done for exactly one cycle, then IDLE with grant_id=0. No arbitration happens in DONE.
- Requesters must deassert req on the edge at which they observe done. A req still high in IDLE is treated as a new request.
- mem_done outside WAIT is ignored.
- Reset values:
  - state IDLE, rr=0, audio_cnt=0.
  - all done outputs, mem_req, mem_we, err and grant_id are 0.
  - mem_addr, mem_wdata and all rdata are 0.
- clr mid-transaction: immediate abort, mem_req drops asynchronously, no done is issued. The memory controller must tolerate a dropped mem_req.

## Timing
- Minimum latency is 2 cycles from req sampled in IDLE (cycle N):
  - N+1: WAIT, mem_req=1.
  - If mem_done is high in N+1: N+2 is DONE with done=1.
  - N+3: IDLE, next arbitration.
- Back-to-back throughput is one transaction per 3 cycles when memory responds immediately.
- mem_req, mem_we, mem_addr, mem_wdata and grant_id are registered. rdata is stable from the done cycle onward.
- Simultaneous requests in the same IDLE cycle are resolved by the priority rules; losers keep waiting with req high.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and counts WAIT cycles.
  - If it reaches TIMEOUT with no mem_done: go to DONE, drop mem_req, set the granted rdata to all ones, and pulse err in the same cycle as done.
- ARB_TIMEOUT_EN undefined:
  - WAIT lasts indefinitely.
  - err is tied 0 and no counter is built.

## Test plan
- Single core read, addr 0x12345, memory returns 0xA5 one cycle after mem_req -> mem_addr=0x12345, mem_we=0; core_done one pulse; core_rdata=0xA5; grant_id sequence 1,1,1,0.
- core_req and io_req asserted together, each re-requesting 4 times -> grants alternate core, io, core, io…; rr starts at core after reset.
- audio_req and core_req continuously high, AUDIO_BURST=2 -> grant pattern audio, audio, core, audio, audio, core.
- IO write, addr 0x00010, data 0x3C, mem_done delayed 10 cycles -> mem_we=1, mem_wdata=0x3C held stable for all 10 cycles; io_done exactly one cycle after mem_done.
- clr asserted during WAIT -> mem_req falls with no clock edge; no done pulse; next request after reset served normally.
- With ARB_TIMEOUT_EN and TIMEOUT=255, mem_done never returned -> after 255 WAIT cycles err=1 and core_done=1 together, core_rdata=0xFF; a mem_done arriving later is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: three-way core/IO/audio arbiter serialising one memory transaction at a time; optional WAIT timeout under ARB_TIMEOUT_EN
module mem_port_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 255,
  parameter int AUDIO_BURST = 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_core_req,
  input  logic              i_io_req,
  input  logic              i_audio_req,
  input  logic              i_core_we,
  input  logic              i_io_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [ADDR_W-1:0] i_io_addr,
  input  logic [ADDR_W-1:0] i_audio_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  input  logic [DATA_W-1:0] i_io_wdata,
  output logic              o_core_done,
  output logic              o_io_done,
  output logic              o_audio_done,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic [DATA_W-1:0] o_io_rdata,
  output logic [DATA_W-1:0] o_audio_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_done,
  output logic [1:0]        o_grant_id,
  output logic              o_err
);
  localparam int CW = $clog2(AUDIO_BURST + 2);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0]        r_state, w_state, r_gid;
  logic              r_rr, r_we;
  logic [CW-1:0]     r_acnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_core_rdata, r_io_rdata, r_audio_rdata, w_rd;
  logic              w_full, w_aud, w_core, w_io, w_any, w_fin, w_to;
  assign w_full = r_acnt == CW'(AUDIO_BURST);
  assign w_aud  = i_audio_req & ~(w_full & (i_core_req | i_io_req));
  assign w_core = ~w_aud & i_core_req & (~i_io_req | ~r_rr);
  assign w_io   = ~w_aud & ~w_core & i_io_req;
  assign w_any  = i_core_req | i_io_req | i_audio_req;
  assign w_fin  = i_mem_done | w_to;
  assign w_rd   = i_mem_done ? i_mem_rdata : '1;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_tcnt;
  logic       r_err;
  assign w_to  = r_tcnt == 8'(TIMEOUT - 1);
  assign o_err = r_err;
  // WAIT-cycle counter, held at zero outside WAIT so it restarts on every entry
  always_ff @(posedge i_clk or posedge i_clr)
    if (i_clr) r_tcnt <= '0;
    else r_tcnt <= r_state == WAIT ? r_tcnt + 8'd1 : 8'd0;
  // err lines up with the done pulse of an aborted transaction
  always_ff @(posedge i_clk or posedge i_clr)
    if (i_clr) r_err <= 1'b0;
    else r_err <= r_state == WAIT && !i_mem_done && w_to;
`else
  assign w_to  = 1'b0;
  assign o_err = 1'b0;
`endif
  // state register
  always_ff @(posedge i_clk or posedge i_clr)
    if (i_clr) r_state <= IDLE;
    else r_state <= w_state;
  // next state
  always_comb
    w_state = r_state == IDLE ? (w_any ? WAIT : IDLE) :
              r_state == WAIT ? (w_fin ? DONE : WAIT) : IDLE;
  // outputs decoded from state and latched grant
  always_comb begin
    o_mem_req    = r_state == WAIT;
    o_core_done  = r_state == DONE && r_gid == 2'd1;
    o_io_done    = r_state == DONE && r_gid == 2'd2;
    o_audio_done = r_state == DONE && r_gid == 2'd3;
  end
  assign o_mem_we      = r_we;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_grant_id    = r_gid;
  assign o_core_rdata  = r_core_rdata;
  assign o_io_rdata    = r_io_rdata;
  assign o_audio_rdata = r_audio_rdata;
  // arbitration in IDLE, read-data capture at the end of WAIT, grant release in DONE
  always_ff @(posedge i_clk or posedge i_clr)
    if (i_clr) begin
      r_gid         <= '0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rr          <= 1'b0;
      r_acnt        <= '0;
      r_core_rdata  <= '0;
      r_io_rdata    <= '0;
      r_audio_rdata <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_gid   <= w_aud ? 2'd3 : w_core ? 2'd1 : 2'd2;
        r_we    <= w_core ? i_core_we : w_io & i_io_we;
        r_addr  <= w_aud ? i_audio_addr : w_core ? i_core_addr : i_io_addr;
        r_wdata <= w_core ? i_core_wdata : w_io ? i_io_wdata : '0;
      end
      r_rr   <= r_rr ^ (w_core | w_io);
      r_acnt <= w_aud ? (w_full ? r_acnt : r_acnt + 1'b1) : '0;
    end else if (r_state == WAIT) begin
      if (w_fin && r_gid == 2'd1) r_core_rdata <= w_rd;
      if (w_fin && r_gid == 2'd2) r_io_rdata <= w_rd;
      if (w_fin && r_gid == 2'd3) r_audio_rdata <= w_rd;
    end else
      r_gid <= '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 0, clr = 1;
  logic        core_req = 0, io_req = 0, audio_req = 0, core_we = 0, io_we = 0;
  logic [18:0] core_addr = 0, io_addr = 0, audio_addr = 0;
  logic [7:0]  core_wdata = 0, io_wdata = 0, mem_rdata = 0;
  logic        mem_done = 0;
  logic        core_done, io_done, audio_done, mem_req, mem_we, err;
  logic [7:0]  core_rdata, io_rdata, audio_rdata, mem_wdata;
  logic [18:0] mem_addr;
  logic [1:0]  grant_id, g;
  int          n_run = 0, n_fail = 0;

  mem_port_arbiter dut (
    .i_clk(clk), .i_clr(clr),
    .i_core_req(core_req), .i_io_req(io_req), .i_audio_req(audio_req),
    .i_core_we(core_we), .i_io_we(io_we),
    .i_core_addr(core_addr), .i_io_addr(io_addr), .i_audio_addr(audio_addr),
    .i_core_wdata(core_wdata), .i_io_wdata(io_wdata),
    .o_core_done(core_done), .o_io_done(io_done), .o_audio_done(audio_done),
    .o_core_rdata(core_rdata), .o_io_rdata(io_rdata), .o_audio_rdata(audio_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_done(mem_done),
    .o_grant_id(grant_id), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr = 1;
    tick();
    tick();
    clr = 0;
  endtask

  task automatic serve(input logic [7:0] rd, output logic [1:0] gid);
    int n = 0;
    while (!mem_req && n < 10) begin
      tick();
      n++;
    end
    n_run++; if (mem_req !== 1'b1) begin n_fail++; $error("FAIL serve_req_seen %0h", mem_req); end
    gid = grant_id;
    mem_done = 1;
    mem_rdata = rd;
    tick();
    mem_done = 0;
    tick();
  endtask

  initial begin
    #2;
    n_run++; if (mem_req !== 1'b0) begin n_fail++; $error("FAIL rst_mem_req"); end
    n_run++; if (grant_id !== 2'd0) begin n_fail++; $error("FAIL rst_grant"); end
    n_run++; if ({core_done, io_done, audio_done, mem_we, err} !== 5'b0) begin n_fail++; $error("FAIL rst_outs"); end
    n_run++; if ({mem_addr, mem_wdata, core_rdata, io_rdata, audio_rdata} !== 51'b0) begin n_fail++; $error("FAIL rst_data"); end
    do_reset();

    core_req = 1; core_we = 0; core_addr = 19'h12345;
    tick();
    n_run++; if (grant_id !== 2'd1) begin n_fail++; $error("FAIL rd_gid1 %0h", grant_id); end
    n_run++; if (mem_req !== 1'b1) begin n_fail++; $error("FAIL rd_req"); end
    n_run++; if (mem_addr !== 19'h12345) begin n_fail++; $error("FAIL rd_addr %0h", mem_addr); end
    n_run++; if (mem_we !== 1'b0) begin n_fail++; $error("FAIL rd_we"); end
    tick();
    n_run++; if (grant_id !== 2'd1) begin n_fail++; $error("FAIL rd_gid2 %0h", grant_id); end
    n_run++; if (core_done !== 1'b0) begin n_fail++; $error("FAIL rd_nodone"); end
    mem_done = 1; mem_rdata = 8'hA5;
    tick();
    mem_done = 0; core_req = 0;
    n_run++; if (grant_id !== 2'd1) begin n_fail++; $error("FAIL rd_gid3 %0h", grant_id); end
    n_run++; if (core_done !== 1'b1) begin n_fail++; $error("FAIL rd_done"); end
    n_run++; if (mem_req !== 1'b0) begin n_fail++; $error("FAIL rd_req_low"); end
    n_run++; if (core_rdata !== 8'hA5) begin n_fail++; $error("FAIL rd_rdata %0h", core_rdata); end
    tick();
    n_run++; if (grant_id !== 2'd0) begin n_fail++; $error("FAIL rd_gid4 %0h", grant_id); end
    n_run++; if (core_done !== 1'b0) begin n_fail++; $error("FAIL rd_done_once"); end
    n_run++; if (core_rdata !== 8'hA5) begin n_fail++; $error("FAIL rd_rdata_hold %0h", core_rdata); end

    do_reset();
    core_req = 1; io_req = 1;
    for (int i = 0; i < 8; i++) begin
      serve(8'(8'h40 + i), g);
      n_run++; if (g !== ((i % 2 == 0) ? 2'd1 : 2'd2)) begin n_fail++; $error("FAIL rr_grant %0d %0h", i, g); end
    end
    n_run++; if (io_rdata !== 8'h47) begin n_fail++; $error("FAIL rr_io_rdata %0h", io_rdata); end
    n_run++; if (core_rdata !== 8'h46) begin n_fail++; $error("FAIL rr_core_rdata %0h", core_rdata); end
    core_req = 0; io_req = 0;

    do_reset();
    audio_req = 1; core_req = 1; audio_addr = 19'h7ABCD;
    for (int i = 0; i < 6; i++) begin
      serve(8'(8'h60 + i), g);
      n_run++; if (g !== ((i % 3 == 2) ? 2'd1 : 2'd3)) begin n_fail++; $error("FAIL burst_grant %0d %0h", i, g); end
    end
    n_run++; if (audio_rdata !== 8'h64) begin n_fail++; $error("FAIL burst_audio_rdata %0h", audio_rdata); end
    audio_req = 0; core_req = 0;

    io_req = 1; io_we = 1; io_addr = 19'h00010; io_wdata = 8'h3C;
    tick();
    n_run++; if (grant_id !== 2'd2) begin n_fail++; $error("FAIL wr_gid %0h", grant_id); end
    n_run++; if (mem_we !== 1'b1) begin n_fail++; $error("FAIL wr_we"); end
    for (int i = 0; i < 10; i++) begin
      n_run++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 19'h00010, 8'h3C}) begin n_fail++; $error("FAIL wr_stable %0d", i); end
      n_run++; if (io_done !== 1'b0) begin n_fail++; $error("FAIL wr_nodone %0d", i); end
      tick();
    end
    mem_done = 1;
    tick();
    mem_done = 0; io_req = 0; io_we = 0;
    n_run++; if (io_done !== 1'b1) begin n_fail++; $error("FAIL wr_done"); end
    tick();
    n_run++; if (io_done !== 1'b0) begin n_fail++; $error("FAIL wr_done_once"); end
    mem_done = 1;
    tick();
    mem_done = 0;
    n_run++; if ({mem_req, core_done, io_done, audio_done, grant_id} !== 6'b0) begin n_fail++; $error("FAIL idle_memdone_ignored"); end

    core_req = 1; core_addr = 19'h00ABC;
    tick();
    n_run++; if (mem_req !== 1'b1) begin n_fail++; $error("FAIL clr_pre_req"); end
    #2 clr = 1;
    #1;
    n_run++; if (mem_req !== 1'b0) begin n_fail++; $error("FAIL clr_async_req"); end
    n_run++; if (grant_id !== 2'd0) begin n_fail++; $error("FAIL clr_async_gid %0h", grant_id); end
    tick();
    core_req = 0;
    n_run++; if (core_done !== 1'b0) begin n_fail++; $error("FAIL clr_no_done"); end
    tick();
    clr = 0;
    core_req = 1; core_addr = 19'h00DEF;
    serve(8'h5A, g);
    core_req = 0;
    n_run++; if (g !== 2'd1) begin n_fail++; $error("FAIL post_clr_gid %0h", g); end
    n_run++; if (core_rdata !== 8'h5A) begin n_fail++; $error("FAIL post_clr_rdata %0h", core_rdata); end

`ifdef ARB_TIMEOUT_EN
    core_req = 1;
    tick();
    for (int i = 0; i < 254; i++) tick();
    n_run++; if ({core_done, err, mem_req} !== 3'b001) begin n_fail++; $error("FAIL to_not_yet"); end
    tick();
    core_req = 0;
    n_run++; if ({core_done, err, mem_req} !== 3'b110) begin n_fail++; $error("FAIL to_err_done"); end
    n_run++; if (core_rdata !== 8'hFF) begin n_fail++; $error("FAIL to_rdata %0h", core_rdata); end
    mem_done = 1;
    tick();
    mem_done = 0;
    n_run++; if ({core_done, err, core_rdata} !== 10'h0FF) begin n_fail++; $error("FAIL to_late_ignored"); end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
